// File: rtl/bench_axi_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bench_axi_master_pkg
//  Description : Register map, status bit positions, error codes and state
//                encodings shared by the benchmark AXI4-Lite initiator.
//  Revision    : 1.0 - initial release
// ============================================================================
package bench_axi_master_pkg;

   // Bench register slave offsets
   localparam logic [5:0] C_REG_CTRL       = 6'h00;
   localparam logic [5:0] C_REG_STATUS     = 6'h04;
   localparam logic [5:0] C_REG_TCOND0     = 6'h08;
   localparam logic [5:0] C_REG_TCOND1     = 6'h0C;
   localparam logic [5:0] C_REG_TCOND2     = 6'h10;
   localparam logic [5:0] C_REG_TCOND3     = 6'h14;
   localparam logic [5:0] C_REG_WIN_ONEHOT = 6'h18;

   // CONTROL bits
   localparam int C_CTRL_START = 0;
   localparam int C_CTRL_SCLR  = 1;

   // STATUS bits
   localparam int C_STATUS_RUN    = 0;
   localparam int C_STATUS_DONE   = 1;
   localparam int C_STATUS_WIN_LO = 2;
   localparam int C_STATUS_WIN_HI = 3;

   // AXI response and result error codes
   localparam logic [1:0] C_RESP_OKAY     = 2'b00;
   localparam logic [1:0] C_ERR_OK        = 2'b00;
   localparam logic [1:0] C_ERR_BRESP     = 2'b01;
   localparam logic [1:0] C_ERR_RRESP     = 2'b10;
   localparam logic [1:0] C_ERR_TIMEOUT   = 2'b11;

   // Index of the last result read (WIN_ONEHOT)
   localparam logic [2:0] C_LAST_IDX = 3'd4;

   // Sequencer states
   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_WR_ADDR   = 4'd1,
      S_WR_RESP   = 4'd2,
      S_POLL_WAIT = 4'd3,
      S_POLL_AR   = 4'd4,
      S_POLL_R    = 4'd5,
      S_RD_AR     = 4'd6,
      S_RD_R      = 4'd7,
      S_FINISH    = 4'd8
   } state_t;

   // Single-transfer engine states
   typedef enum logic [2:0] {
      X_IDLE  = 3'd0,
      X_WADDR = 3'd1,
      X_WRESP = 3'd2,
      X_RADDR = 3'd3,
      X_RDATA = 3'd4
   } xfer_state_t;

   // Address of result register idx (0..3 = TCOND0..3, 4 = WIN_ONEHOT)
   function automatic logic [5:0] result_addr(input logic [2:0] idx);
      return C_REG_TCOND0 + {1'b0, idx, 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_single_xfer.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_single_xfer
//  Description : Performs exactly one AXI4-Lite write or read per start pulse.
//                Returns addr_done when the address (and data) beats are
//                accepted, then done with the response and read data. A new
//                start may be issued on the same cycle as done.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_single_xfer
   import bench_axi_master_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_write,
   input  logic [5:0]  addr,
   input  logic [31:0] wr_data,
   output logic        addr_done,
   output logic        done,
   output logic [1:0]  resp,
   output logic [31:0] rd_data,
   output logic [5:0]  m_axi_awaddr,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   output logic [5:0]  m_axi_araddr,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready
);

   xfer_state_t r_state;
   xfer_state_t w_state_nxt;

   logic        r_awvalid;
   logic        r_wvalid;
   logic        r_arvalid;
   logic [5:0]  r_awaddr;
   logic [5:0]  r_araddr;
   logic [31:0] r_wdata;

   logic w_aw_hs;
   logic w_w_hs;
   logic w_ar_hs;
   logic w_wr_addr_done;
   logic w_rd_addr_done;
   logic w_b_done;
   logic w_r_done;
   logic w_launch;

   assign w_aw_hs = r_awvalid & m_axi_awready;
   assign w_w_hs  = r_wvalid  & m_axi_wready;
   assign w_ar_hs = r_arvalid & m_axi_arready;

   // Write address phase ends once neither AW nor W is still waiting
   assign w_wr_addr_done = (r_state == X_WADDR) &
                           ~(r_awvalid & ~m_axi_awready) &
                           ~(r_wvalid  & ~m_axi_wready);
   assign w_rd_addr_done = (r_state == X_RADDR) & w_ar_hs;
   assign w_b_done       = (r_state == X_WRESP) & m_axi_bvalid;
   assign w_r_done       = (r_state == X_RDATA) & m_axi_rvalid;
   assign w_launch       = start & ((r_state == X_IDLE) | w_b_done | w_r_done);

   assign addr_done = w_wr_addr_done | w_rd_addr_done;
   assign done      = w_b_done | w_r_done;
   assign resp      = (r_state == X_WRESP) ? m_axi_bresp : m_axi_rresp;
   assign rd_data   = m_axi_rdata;

   assign m_axi_awaddr  = r_awaddr;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_wstrb   = 4'hF;
   assign m_axi_wvalid  = r_wvalid;
   assign m_axi_bready  = (r_state == X_WRESP);
   assign m_axi_araddr  = r_araddr;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_rready  = (r_state == X_RDATA);

   // Transfer state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= X_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next transfer phase; a start overrides the return to idle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         X_IDLE:  w_state_nxt = X_IDLE;
         X_WADDR: if (w_wr_addr_done) w_state_nxt = X_WRESP;
         X_WRESP: if (w_b_done)       w_state_nxt = X_IDLE;
         X_RADDR: if (w_rd_addr_done) w_state_nxt = X_RDATA;
         X_RDATA: if (w_r_done)       w_state_nxt = X_IDLE;
         default: w_state_nxt = X_IDLE;
      endcase
      if (w_launch) w_state_nxt = is_write ? X_WADDR : X_RADDR;
   end

   // Address/data registers and independently dropped valids
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_arvalid <= 1'b0;
         r_awaddr  <= 6'h00;
         r_araddr  <= 6'h00;
         r_wdata   <= 32'h0;
      end else if (w_launch) begin
         r_awvalid <= is_write;
         r_wvalid  <= is_write;
         r_arvalid <= ~is_write;
         if (is_write) begin
            r_awaddr <= addr;
            r_wdata  <= wr_data;
         end else begin
            r_araddr <= addr;
         end
      end else begin
         if (w_aw_hs) r_awvalid <= 1'b0;
         if (w_w_hs)  r_wvalid  <= 1'b0;
         if (w_ar_hs) r_arvalid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bench_axi_master.sv
`default_nettype none
// ============================================================================
//  Module      : bench_axi_master
//  Description : AXI4-Lite initiator that starts one router benchmark, polls
//                STATUS until done, reads TCOND0..3 and WIN_ONEHOT and
//                presents them on a parallel result bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module bench_axi_master
   import bench_axi_master_pkg::*;
#(
   parameter int unsigned POLL_GAP    = 16,
   parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000,
   parameter bit          AUTO_RUN    = 1'b0
)(
   input  logic        m_axi_aclk,
   input  logic        m_axi_aresetn,
   input  logic        run_req,
   output logic [5:0]  m_axi_awaddr,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   output logic [5:0]  m_axi_araddr,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   output logic        busy,
   output logic        res_valid,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [31:0] t_cond0,
   output logic [31:0] t_cond1,
   output logic [31:0] t_cond2,
   output logic [31:0] t_cond3,
   output logic [3:0]  win_onehot,
   output logic [1:0]  winner_code
);

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_busy;
   logic        r_err;
   logic [1:0]  r_err_code;
   logic        r_auto_pend;
   logic [2:0]  r_idx;
   logic [31:0] r_gap_cnt;
   logic [31:0] r_tmo_cnt;
   logic [31:0] r_t_cond [4];
   logic [3:0]  r_win;
   logic [1:0]  r_winner;

   logic        w_go;
   logic        w_fail;
   logic [1:0]  w_fail_code;
   logic        w_gap_last;
   logic        w_x_start;
   logic        w_x_write;
   logic [5:0]  w_x_addr;
   logic [31:0] w_x_wdata;
   logic        w_x_addr_done;
   logic        w_x_done;
   logic [1:0]  w_x_resp;
   logic [31:0] w_x_rdata;
   logic        w_x_ok;
   logic        w_x_bad;

   assign w_x_ok     = w_x_done & (w_x_resp == C_RESP_OKAY);
   assign w_x_bad    = w_x_done & (w_x_resp != C_RESP_OKAY);
   assign w_gap_last = (r_gap_cnt == POLL_GAP - 1);

   axi_lite_single_xfer u_xfer (
      .clk           (m_axi_aclk),
      .rst_n         (m_axi_aresetn),
      .start         (w_x_start),
      .is_write      (w_x_write),
      .addr          (w_x_addr),
      .wr_data       (w_x_wdata),
      .addr_done     (w_x_addr_done),
      .done          (w_x_done),
      .resp          (w_x_resp),
      .rd_data       (w_x_rdata),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_bresp   (m_axi_bresp),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready)
   );

   assign busy        = r_busy;
   assign res_valid   = (r_state == S_FINISH);
   assign err         = r_err;
   assign err_code    = r_err_code;
   assign t_cond0     = r_t_cond[0];
   assign t_cond1     = r_t_cond[1];
   assign t_cond2     = r_t_cond[2];
   assign t_cond3     = r_t_cond[3];
   assign win_onehot  = r_win;
   assign winner_code = r_winner;

   // Sequencer state register
   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) r_state <= S_IDLE;
      else                r_state <= w_state_nxt;
   end

   // Next state and transfer requests; next transfer launches on the cycle
   // the previous one completes so no idle cycle is inserted between them
   always_comb begin
      w_state_nxt = r_state;
      w_go        = 1'b0;
      w_fail      = 1'b0;
      w_fail_code = C_ERR_OK;
      w_x_start   = 1'b0;
      w_x_write   = 1'b0;
      w_x_addr    = C_REG_CTRL;
      w_x_wdata   = 32'h0;
      case (r_state)
         S_IDLE: begin
            if (run_req || r_auto_pend) begin
               w_go        = 1'b1;
               w_x_start   = 1'b1;
               w_x_write   = 1'b1;
               w_x_addr    = C_REG_CTRL;
               w_x_wdata   = 32'h1 << C_CTRL_START;
               w_state_nxt = S_WR_ADDR;
            end
         end
         S_WR_ADDR: if (w_x_addr_done) w_state_nxt = S_WR_RESP;
         S_WR_RESP: begin
            if (w_x_bad) begin
               w_fail      = 1'b1;
               w_fail_code = C_ERR_BRESP;
               w_state_nxt = S_FINISH;
            end else if (w_x_ok) begin
               w_state_nxt = S_POLL_WAIT;
            end
         end
         S_POLL_WAIT: begin
            if (r_tmo_cnt >= TIMEOUT_CYC) begin
               w_fail      = 1'b1;
               w_fail_code = C_ERR_TIMEOUT;
               w_state_nxt = S_FINISH;
            end else if (w_gap_last) begin
               w_x_start   = 1'b1;
               w_x_addr    = C_REG_STATUS;
               w_state_nxt = S_POLL_AR;
            end
         end
         S_POLL_AR: if (w_x_addr_done) w_state_nxt = S_POLL_R;
         S_POLL_R: begin
            if (w_x_bad) begin
               w_fail      = 1'b1;
               w_fail_code = C_ERR_RRESP;
               w_state_nxt = S_FINISH;
            end else if (w_x_ok) begin
               if (w_x_rdata[C_STATUS_DONE]) begin
                  w_x_start   = 1'b1;
                  w_x_addr    = result_addr(3'd0);
                  w_state_nxt = S_RD_AR;
               end else begin
                  w_state_nxt = S_POLL_WAIT;
               end
            end
         end
         S_RD_AR: if (w_x_addr_done) w_state_nxt = S_RD_R;
         S_RD_R: begin
            if (w_x_bad) begin
               w_fail      = 1'b1;
               w_fail_code = C_ERR_RRESP;
               w_state_nxt = S_FINISH;
            end else if (w_x_ok) begin
               if (r_idx == C_LAST_IDX) begin
                  w_state_nxt = S_FINISH;
               end else begin
                  w_x_start   = 1'b1;
                  w_x_addr    = result_addr(r_idx + 3'd1);
                  w_state_nxt = S_RD_AR;
               end
            end
         end
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Status flags, poll/timeout counters and result capture
   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_err_code  <= C_ERR_OK;
         r_auto_pend <= AUTO_RUN;
         r_idx       <= 3'd0;
         r_gap_cnt   <= 32'd0;
         r_tmo_cnt   <= 32'd0;
         r_t_cond[0] <= 32'h0;
         r_t_cond[1] <= 32'h0;
         r_t_cond[2] <= 32'h0;
         r_t_cond[3] <= 32'h0;
         r_win       <= 4'h0;
         r_winner    <= 2'b00;
      end else begin
         // Auto-run only gets the first post-reset cycle
         r_auto_pend <= 1'b0;

         if (w_go) begin
            r_busy     <= 1'b1;
            r_err      <= 1'b0;
            r_err_code <= C_ERR_OK;
         end
         if (r_state == S_FINISH) r_busy <= 1'b0;
         // err/err_code settle on entry to FINISH so they are valid with res_valid
         if ((w_state_nxt == S_FINISH) && (r_state != S_FINISH)) begin
            r_err      <= w_fail;
            r_err_code <= w_fail_code;
         end

         if (r_state == S_POLL_WAIT) r_gap_cnt <= w_gap_last ? 32'd0 : r_gap_cnt + 32'd1;
         else                        r_gap_cnt <= 32'd0;

         case (r_state)
            S_WR_RESP: r_tmo_cnt <= 32'd0;
            S_POLL_WAIT, S_POLL_AR, S_POLL_R, S_RD_AR, S_RD_R:
               if (r_tmo_cnt != 32'hFFFF_FFFF) r_tmo_cnt <= r_tmo_cnt + 32'd1;
            default: r_tmo_cnt <= r_tmo_cnt;
         endcase

         if ((r_state == S_POLL_R) && w_x_ok)
            r_winner <= w_x_rdata[C_STATUS_WIN_HI:C_STATUS_WIN_LO];

         if (r_state == S_POLL_R) r_idx <= 3'd0;
         else if ((r_state == S_RD_R) && w_x_ok) r_idx <= r_idx + 3'd1;

         if ((r_state == S_RD_R) && w_x_ok) begin
            case (r_idx)
               3'd0:    r_t_cond[0] <= w_x_rdata;
               3'd1:    r_t_cond[1] <= w_x_rdata;
               3'd2:    r_t_cond[2] <= w_x_rdata;
               3'd3:    r_t_cond[3] <= w_x_rdata;
               default: r_win       <= w_x_rdata[3:0];
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/bench_axi_master.md
Name: bench_axi_master

Overview:
- AXI4-Lite initiator that runs one router benchmark on the bench's AXI4-Lite register slave and collects the results.
- On a run request it writes CONTROL.start, polls STATUS until done, reads TCOND0..3 and WIN_ONEHOT, then presents them on a parallel result bus.
- Sits between board-level control (button, UART command decoder or auto-run) and the bench register slave. No processor is required.

Parameters:
- POLL_GAP, 16, idle cycles between consecutive STATUS reads (minimum 1).
- TIMEOUT_CYC, 32'd1_000_000, cycles from start-write completion to abort if done is never seen.
- AUTO_RUN, 0, 1 = launch one run automatically on the first cycle after reset release.

Ports:
- m_axi_aclk  in  1  clock
- m_axi_aresetn  in  1  asynchronous active-low reset
- run_req  in  1  single-cycle run request; ignored while busy
- m_axi_awaddr  out  6  write address
- m_axi_awvalid  out  1  write address valid
- m_axi_awready  in  1  write address ready
- m_axi_wdata  out  32  write data
- m_axi_wstrb  out  4  write strobes, always 4'hF
- m_axi_wvalid  out  1  write data valid
- m_axi_wready  in  1  write data ready
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  write response valid
- m_axi_bready  out  1  write response ready
- m_axi_araddr  out  6  read address
- m_axi_arvalid  out  1  read address valid
- m_axi_arready  in  1  read address ready
- m_axi_rdata  in  32  read data
- m_axi_rresp  in  2  read response
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data ready
- busy  out  1  sequence in progress
- res_valid  out  1  one-cycle pulse when the sequence ends, on success or error
- err  out  1  last run failed; held until the next run is accepted
- err_code  out  2  00 ok, 01 BRESP!=0, 10 RRESP!=0, 11 timeout
- t_cond0..t_cond3  out  32 each  captured TCOND0..3
- win_onehot  out  4  captured WIN_ONEHOT[3:0]
- winner_code  out  2  STATUS[3:2] from the final poll

Behaviour:
- Reset (asynchronous, active-low):
  - All AXI valid/ready outputs go to 0 immediately; addresses and wdata go to 0.
  - busy, res_valid, err and err_code are 0; all result registers are 0.
  - State is IDLE.
- Reset asserted mid-transaction: the block abandons the transaction. There is no recovery handshake; the slave shares the same reset.
- States: IDLE, WR_ADDR, WR_RESP, POLL_WAIT, POLL_AR, POLL_R, RD_AR, RD_R, FINISH.
- IDLE:
  - Entry condition is run_req=1, or the first cycle after reset release when AUTO_RUN=1.
  - Next cycle: busy=1, err=0, err_code=00, awaddr=0x00, wdata=32'h1, awvalid=wvalid=1.
- WR_ADDR:
  - awvalid and wvalid are each held until their own ready is sampled high, then dropped independently. AW-before-W, W-before-AW and simultaneous acceptance must all work.
  - When both have been accepted, go to WR_RESP.
- WR_RESP:
  - bready=1 until bvalid.
  - If bresp!=0: err_code=01, go to FINISH.
  - Otherwise clear the timeout counter and go to POLL_WAIT.
- POLL_WAIT:
  - Count POLL_GAP cycles, then go to POLL_AR.
  - If the timeout counter reaches TIMEOUT_CYC: err_code=11, go to FINISH.
  - Timeout is checked only here; an outstanding AXI transaction is never abandoned.
- POLL_AR: araddr=0x04, arvalid held until arready, then go to POLL_R.
- POLL_R:
  - rready=1 until rvalid.
  - If rresp!=0: err_code=10, go to FINISH.
  - Otherwise winner_code<=rdata[3:2]. If rdata[1]=1 go to RD_AR with idx=0; else go to POLL_WAIT.
- RD_AR / RD_R:
  - araddr = 0x08 + 4*idx for idx 0..4.
  - Capture rdata into t_cond0..3 for idx 0..3, and rdata[3:0] into win_onehot for idx 4.
  - If rresp!=0: err_code=10, go to FINISH.
  - After idx 4, go to FINISH.
- Timeout counter: 32-bit, saturating; runs from WR_RESP exit until FINISH.
- FINISH (one cycle): res_valid=1, busy<=0, err=(err_code!=0), then IDLE.
- Result registers: keep their previous values on error, except registers already captured during the failing run.
- Only one AXI transaction is outstanding at a time. The block never asserts arvalid while a write is pending.
- Latency:
  - run_req in cycle 0 → awvalid in cycle 1.
  - With zero-wait slave ready and done already set, res_valid appears 1 + 2 (write) + POLL_GAP + 2 (poll) + 5×2 (reads) + 1 cycles later.
- run_req while busy is ignored; it is not queued. run_req on the FINISH cycle is also ignored.

Decomposition:
- Shared header bench_regs.vh holds:
  - register offsets CTRL=0x00, STATUS=0x04, TCOND0..3=0x08..0x14, WIN_ONEHOT=0x18;
  - CTRL_START=bit0, CTRL_SCLR=bit1;
  - STATUS bit positions;
  - error code localparams;
  - state encodings.
- One sub-module, axi_lite_single_xfer. It performs one write or one read: it issues the transaction, handles the valid/ready handshakes, and returns done, resp and rdata. The top FSM sequences calls to it.

Test Plan:
- Zero-wait slave BFM; STATUS done on the 3rd poll; TCOND=0x11,0x22,0x33,0x44; WIN=0x8; STATUS=0x0E → res_valid once, err=0, t_cond0..3 match, win_onehot=4'h8, winner_code=2'b11, exactly 1 write and 3+5 reads observed.
- Slave delays awready 3 cycles after wready (and the reverse case) → each valid is held until its own ready, no duplicate AW/W beat, sequence completes normally.
- BRESP=2'b10 on the CONTROL write → no reads issued, res_valid with err=1, err_code=01.
- RRESP=2'b10 on the TCOND2 read → t_cond0/1 updated, t_cond2/3 unchanged, err_code=10.
- TIMEOUT_CYC=200, STATUS never done → res_valid about 200 cycles after the write, err_code=11, no transaction left pending; a new run_req restarts cleanly.
- Other cases, each with the stated response:
  - aresetn pulsed low while arvalid=1 → arvalid drops in the same cycle and busy=0.
  - run_req while busy → ignored.
  - AUTO_RUN=1 → run starts with no run_req.
